stmtlocals_acc_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-lane combinational increment cosim spec.
- Splits a wide input word into `LANES` independent lanes of `LANE_W` bits.
- Each lane adds twice the increment, either as a pass-through or into a per-lane running accumulator with a sticky overflow flag.
- Valid/ready handshakes on both sides; used as a cosim spec exercising statement-local temporaries inside clocked blocks.

---
 rtl/stmtlocals_pkg.sv | 13 +
 rtl/stmtlocals_lane.sv | 74 +++++++
 rtl/stmtlocals_acc_pipe.sv | 86 ++++++++
 tb/tb_stmtlocals_acc_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stmtlocals_pkg.sv
// Shared types and default sizes for the lane-parallel
// increment/accumulate pipeline.
package stmtlocals_pkg;

    typedef enum logic {
        MODE_INC = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

    localparam int LANES_DEF  = 4;
    localparam int LANE_W_DEF = 32;

endpackage

// File: rtl/stmtlocals_lane.sv
// One lane: S1 temporary, S2 result, running accumulator and
// sticky overflow flag. Enables come from the pipeline control.
module stmtlocals_lane
    import stmtlocals_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF,
    parameter int INC    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              xfer_i,
    input  logic              clr_i,
    input  mode_e             mode_i,
    input  logic [LANE_W-1:0] in_i,
    output logic [LANE_W-1:0] out_o,
    output logic              ovf_o
);

    logic [LANE_W:0]   tmp_q, tmp_d;
    logic [LANE_W-1:0] acc_q, acc_d;
    logic [LANE_W-1:0] out_q, out_d;
    logic              ovf_q, ovf_d;

    logic [LANE_W-1:0] acc_base;
    logic              ovf_base;
    logic [LANE_W+1:0] sum;

    always_comb begin
        // clear lands before any same-edge accumulate
        acc_base = clr_i ? '0 : acc_q;
        ovf_base = clr_i ? 1'b0 : ovf_q;
        sum      = {2'b00, acc_base} + {1'b0, tmp_q}
                 + (LANE_W+2)'(INC);

        tmp_d = tmp_q;
        acc_d = acc_base;
        ovf_d = ovf_base;
        out_d = out_q;

        if (load_i) begin
            tmp_d = {1'b0, in_i} + (LANE_W+1)'(INC);
        end

        if (xfer_i) begin
            if (mode_i == MODE_ACC) begin
                acc_d = sum[LANE_W-1:0];
                out_d = sum[LANE_W-1:0];
                ovf_d = ovf_base
                      | (sum[LANE_W+1:LANE_W] != 2'b00);
            end else begin
                out_d = tmp_q[LANE_W-1:0] + (LANE_W)'(INC);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmp_q <= '0;
            acc_q <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            tmp_q <= tmp_d;
            acc_q <= acc_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_o = out_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/stmtlocals_acc_pipe.sv
// Two-stage valid/ready pipeline around LANES independent
// increment/accumulate lanes.
module stmtlocals_acc_pipe
    import stmtlocals_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int INC    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in,
    input  logic                    mode,
    input  logic                    clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out,
    output logic [LANES-1:0]        ovf
);

    logic  s1_valid_q, s1_valid_d;
    logic  s2_valid_q, s2_valid_d;
    mode_e s1_mode_q, s1_mode_d;

    logic s2_adv;
    logic accept;
    logic xfer;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = rst_n && (!s1_valid_q || s2_adv);
    assign accept   = in_valid && in_ready;
    assign xfer     = s1_valid_q && s2_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s1_mode_d  = s1_mode_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_mode_d  = mode_e'(mode);
        end else if (xfer) begin
            s1_valid_d = 1'b0;
        end

        if (xfer) begin
            s2_valid_d = 1'b1;
        end else if (s2_adv) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_mode_q  <= MODE_INC;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_mode_q  <= s1_mode_d;
        end
    end

    assign out_valid = s2_valid_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        stmtlocals_lane #(
            .LANE_W (LANE_W),
            .INC    (INC)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (accept),
            .xfer_i (xfer),
            .clr_i  (clr),
            .mode_i (s1_mode_q),
            .in_i   (in[k*LANE_W +: LANE_W]),
            .out_o  (out[k*LANE_W +: LANE_W]),
            .ovf_o  (ovf[k])
        );
    end

endmodule

// File: tb/tb_stmtlocals_acc_pipe.sv
// Directed-vector bench with an expected-result queue drained by
// a monitor whenever the pipeline hands a result downstream.
module tb_stmtlocals_acc_pipe;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int DW = N * W;

    typedef struct packed {
        logic [DW-1:0] o;
        logic [N-1:0]  f;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          mode = 1'b0;
    logic          clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [N-1:0]  ovf;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    stmtlocals_acc_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .mode      (mode),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_data),
        .ovf       (ovf)
    );

    function automatic logic [DW-1:0] pk(input logic [W-1:0] l3,
                                         input logic [W-1:0] l2,
                                         input logic [W-1:0] l1,
                                         input logic [W-1:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] got,
                       input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, want);
        end
    endtask

    // offer one word; returns #1 after the accepting edge
    // (or after the following edge when clr is pulsed there)
    task automatic send(input logic [DW-1:0] w, input logic m,
                        input logic [DW-1:0] eo,
                        input logic [N-1:0] ev, input bit clr_xfer);
        bit ok;
        ok = 1'b0;
        in_data  = w;
        mode     = m;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                exp_q.push_back({eo, ev});
            end
        end
        chk("accept", DW'(ok), DW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (clr_xfer) begin
            clr = 1'b1;
            @(posedge clk);
            #1;
            clr = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
        end
        chk("idle", DW'(ok), DW'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nacc;
        int   wv;
        bit   took;
        exp_t e;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out got=%0h", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out", out_data, e.o);
                        chk("ovf", DW'(ovf), DW'(e.f));
                    end
                end
            end
        join_none

        // reset state
        #2;
        chk("rst_in_ready", DW'(in_ready), DW'(0));
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_out", out_data, '0);
        chk("rst_ovf", DW'(ovf), DW'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;

        // pass-through with lane wrap, plus latency
        send(pk(0, 0, 32'hFFFF_FFFF, 5), 1'b0,
             pk(2, 2, 1, 7), 4'b0000, 1'b0);
        @(negedge clk);
        chk("lat_s1", DW'(out_valid), DW'(0));
        @(negedge clk);
        chk("lat_s2", DW'(out_valid), DW'(1));
        @(posedge clk);
        #1;

        // accumulate
        wait_idle();
        pulse_clr();
        send(pk(0, 0, 0, 10), 1'b1, pk(2, 2, 2, 12), 4'b0000, 1'b0);
        send(pk(0, 0, 0, 20), 1'b1, pk(4, 4, 4, 34), 4'b0000, 1'b0);

        // overflow, stickiness, clear
        wait_idle();
        pulse_clr();
        send(pk(0, 0, 0, 32'hFFFF_FFEE), 1'b1,
             pk(2, 2, 2, 32'hFFFF_FFF0), 4'b0000, 1'b0);
        send(pk(0, 0, 0, 32'h10), 1'b1,
             pk(4, 4, 4, 2), 4'b0001, 1'b0);
        send(pk(0, 0, 0, 3), 1'b0, pk(2, 2, 2, 5), 4'b0001, 1'b0);
        wait_idle();
        chk("ovf_sticky", DW'(ovf), DW'(4'b0001));
        pulse_clr();
        @(negedge clk);
        chk("ovf_clr", DW'(ovf), DW'(0));
        @(posedge clk);
        #1;
        send(pk(0, 0, 0, 0), 1'b0, pk(2, 2, 2, 2), 4'b0000, 1'b0);

        // backpressure
        wait_idle();
        out_ready = 1'b0;
        nacc      = 0;
        wv        = 1;
        mode      = 1'b0;
        in_data   = pk(0, 0, 0, 1);
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            took = in_ready;
            if (took) begin
                exp_q.push_back({pk(2, 2, 2, W'(wv + 2)), 4'b0000});
                nacc++;
            end
            @(posedge clk);
            #1;
            if (took) begin
                wv++;
                in_data = pk(0, 0, 0, W'(wv));
            end
        end
        @(negedge clk);
        chk("stall_count", DW'(nacc), DW'(2));
        chk("stall_rdy", DW'(in_ready), DW'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_gap", DW'(out_valid), DW'(1));
            took = in_valid && in_ready;
            if (took) begin
                exp_q.push_back({pk(2, 2, 2, W'(wv + 2)), 4'b0000});
            end
            @(posedge clk);
            #1;
            if (took) in_valid = 1'b0;
        end

        // clear coincident with accumulate transfer
        wait_idle();
        pulse_clr();
        send(pk(0, 0, 0, 98), 1'b1, pk(2, 2, 2, 100), 4'b0000, 1'b0);
        wait_idle();
        send(pk(0, 0, 0, 7), 1'b1, pk(2, 2, 2, 9), 4'b0000, 1'b1);
        send(pk(0, 0, 0, 0), 1'b1, pk(4, 4, 4, 11), 4'b0000, 1'b0);

        // reset with both stages full
        wait_idle();
        pulse_clr();
        send(pk(32'hFFFF_FFFF, 0, 0, 48), 1'b1,
             pk(1, 2, 2, 50), 4'b1000, 1'b0);
        wait_idle();
        out_ready = 1'b0;
        mode      = 1'b1;
        in_data   = pk(0, 0, 0, 5);
        in_valid  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_rdy", DW'(in_ready), DW'(0));
        chk("full_valid", DW'(out_valid), DW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", DW'(out_valid), DW'(0));
        chk("mid_rst_out", out_data, '0);
        chk("mid_rst_ovf", DW'(ovf), DW'(0));
        chk("mid_rst_rdy", DW'(in_ready), DW'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst2", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;
        send(pk(0, 0, 0, 1), 1'b1, pk(2, 2, 2, 3), 4'b0000, 1'b0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
